// File: rtl/bnn_param_loader.sv
// -----------------------------------------------------------------------------
// bnn_param_loader
//   Setup-phase sequencer for the daisy-chained neuron parameter shift chain.
//   Parameter bytes arrive on a valid/ready stream. Each byte is serialised
//   MSB-first onto o_chain_param, with o_chain_setup high for exactly one cycle
//   per bit. Loading stops after NEURONS*(INPUTS+BIAS_BITS) bits. After that the
//   chain is held frozen and inference is enabled.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_rst_n        synchronous active-low reset
//   i_start        begin a load (honoured in IDLE or DONE only)
//   i_abort        cancel the load in progress
//   i_in_data      parameter byte, bit 7 shifted first
//   i_in_valid     i_in_data valid
//   o_in_ready     loader can accept a byte this cycle
//   o_chain_setup  shift strobe to every neuron
//   o_chain_param  serial data into the first neuron
//   o_busy         load in progress
//   o_loaded       chain holds a complete parameter set
//   o_infer_en     same as o_loaded, gates downstream output capture
//   o_bit_count    bits shifted so far in the current load
// -----------------------------------------------------------------------------
module bnn_param_loader #(
  parameter  int NEURONS    = 4,
  parameter  int INPUTS     = 8,
  parameter  int BIAS_BITS  = 3,
  localparam int TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS),
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_chain_setup,
  output logic             o_chain_param,
  output logic             o_busy,
  output logic             o_loaded,
  output logic             o_infer_en,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam int TOTAL_BYTES = (TOTAL_BITS + 7) / 8;
  localparam int LAST_BITS   = TOTAL_BITS % 8;
  localparam int ACC_W       = $clog2(TOTAL_BYTES + 1);
  // Only the leading bits of the final byte belong to the chain; the rest are dropped.
  localparam logic [3:0] FINAL_BITS = (LAST_BITS == 0) ? 4'd8 : 4'(LAST_BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_buf;
  logic [3:0]       r_bits_left;
  logic [ACC_W-1:0] r_bytes_acc;
  logic [CNT_W-1:0] r_bit_count;

  logic w_in_ready;
  logic w_xfer;
  logic w_shift;
  logic w_last_byte;
  logic w_last_bit;

  // Ready depends on registered state only, so it never loops back through i_in_valid.
  assign w_in_ready  = (r_state == S_LOAD) && (r_bits_left == 4'd0) &&
                       (r_bytes_acc < ACC_W'(TOTAL_BYTES));
  assign w_xfer      = w_in_ready && i_in_valid;
  assign w_shift     = (r_state == S_LOAD) && (r_bits_left != 4'd0);
  assign w_last_byte = (r_bytes_acc == ACC_W'(TOTAL_BYTES - 1));
  assign w_last_bit  = (r_bit_count == CNT_W'(TOTAL_BITS - 1));

  assign o_in_ready    = w_in_ready;
  assign o_chain_setup = w_shift;
  assign o_chain_param = w_shift & r_buf[7];
  assign o_busy        = (r_state == S_LOAD);
  assign o_loaded      = (r_state == S_DONE);
  assign o_infer_en    = (r_state == S_DONE);
  assign o_bit_count   = r_bit_count;

  // Control path: state, byte/bit bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bits_left <= 4'd0;
      r_bytes_acc <= '0;
      r_bit_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_bits_left <= 4'd0;
            r_bytes_acc <= '0;
            r_bit_count <= '0;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            // Abort wins over a same-cycle handshake; that byte is dropped.
            r_state     <= S_IDLE;
            r_bits_left <= 4'd0;
          end else if (w_shift) begin
            r_bits_left <= r_bits_left - 4'd1;
            r_bit_count <= r_bit_count + CNT_W'(1);
            if (w_last_bit) begin
              r_state <= S_DONE;
            end
          end else if (w_xfer) begin
            r_bits_left <= w_last_byte ? FINAL_BITS : 4'd8;
            r_bytes_acc <= r_bytes_acc + ACC_W'(1);
          end
        end
        S_DONE: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_bits_left <= 4'd0;
            r_bytes_acc <= '0;
            r_bit_count <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data path: byte buffer shifts left, bit 7 feeds the chain.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_LOAD) && i_abort) begin
      r_buf <= 8'd0;
    end else if (w_shift) begin
      r_buf <= {r_buf[6:0], 1'b0};
    end else if (w_xfer) begin
      r_buf <= i_in_data;
    end
  end

endmodule
